// File: rtl/garden_zone_scheduler.sv
// Multi-zone garden actuator scheduler: per-zone BCD start/stop windows, manual override,
// soil-wet inhibit, run-time limit, hold-off, and a round-robin cap on concurrently running zones.
module garden_zone_scheduler #(
    parameter int NUM_ZONES  = 4,
    parameter int MAX_ACTIVE = 2,
    parameter int MAX_RUN_S  = 600,
    parameter int HOLDOFF_S  = 30,
    parameter int ZW         = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            time_bcd,
    input  logic                   tick_1hz,
    input  logic                   cfg_we,
    input  logic [ZW-1:0]          cfg_zone,
    input  logic [1:0]             cfg_sel,
    input  logic [15:0]            cfg_data,
    input  logic [NUM_ZONES-1:0]   man_on,
    input  logic [NUM_ZONES-1:0]   man_off,
    input  logic [NUM_ZONES-1:0]   inhibit,
    output logic [NUM_ZONES-1:0]   zone_on,
    output logic [2*NUM_ZONES-1:0] zone_state,
    output logic [4:0]             active_cnt,
    output logic                   cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } zone_state_t;

    localparam int RTW = (MAX_RUN_S > 1) ? $clog2(MAX_RUN_S) : 1;
    localparam int HTW = (HOLDOFF_S > 1) ? $clog2(HOLDOFF_S) : 1;

    function automatic logic hhmm_valid(input logic [15:0] d);
        logic ok;
        ok = (d[15:12] <= 4'd9) && (d[11:8] <= 4'd9) && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
        // With every digit decimal, a plain byte compare of the BCD pair bounds HH and MM.
        ok = ok && (d[15:8] <= 8'h23) && (d[7:0] <= 8'h59);
        return ok;
    endfunction

    function automatic logic in_window(input logic [15:0] s, input logic [15:0] e,
                                       input logic [15:0] t);
        logic w;
        if (s < e) begin
            w = (t >= s) && (t < e);
        end else if (s > e) begin
            w = (t >= s) || (t < e);
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

    function automatic logic [4:0] popcnt(input logic [NUM_ZONES-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    zone_state_t            state_r       [NUM_ZONES];
    zone_state_t            state_nx_s    [NUM_ZONES];
    logic [RTW-1:0]         run_tmr_r     [NUM_ZONES];
    logic [RTW-1:0]         run_tmr_nx_s  [NUM_ZONES];
    logic [HTW-1:0]         hold_tmr_r    [NUM_ZONES];
    logic [HTW-1:0]         hold_tmr_nx_s [NUM_ZONES];
    logic [15:0]            start_r       [NUM_ZONES];
    logic [15:0]            stop_r        [NUM_ZONES];
    logic [NUM_ZONES-1:0]   en_r;
    logic [NUM_ZONES-1:0]   ovr_r;
    logic [NUM_ZONES-1:0]   pend_off_r;
    logic [NUM_ZONES-1:0]   req_s;
    logic [NUM_ZONES-1:0]   exit_run_s;
    logic [NUM_ZONES-1:0]   cand_s;
    logic [NUM_ZONES-1:0]   gnt_s;
    logic [NUM_ZONES-1:0]   run_mask_nx_s;
    logic [2*NUM_ZONES-1:0] state_vec_nx_s;
    logic [ZW-1:0]          rr_r;
    logic [ZW-1:0]          rr_nx_s;
    logic [4:0]             keep_cnt_s;
    logic                   cfg_ok_s;

    // Config write validation
    always_comb begin
        cfg_ok_s = 1'b0;
        if (int'(cfg_zone) >= NUM_ZONES) begin
            cfg_ok_s = 1'b0;
        end else begin
            case (cfg_sel)
                2'd0, 2'd1: cfg_ok_s = hhmm_valid(cfg_data);
                2'd2:       cfg_ok_s = 1'b1;
                default:    cfg_ok_s = 1'b0;
            endcase
        end
    end

    // Config registers and reject pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                start_r[z] <= 16'h0000;
                stop_r[z]  <= 16'h0000;
            end
            en_r    <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~cfg_ok_s;
            if (cfg_we && cfg_ok_s) begin
                for (int z = 0; z < NUM_ZONES; z++) begin
                    if (cfg_zone == ZW'(z)) begin
                        case (cfg_sel)
                            2'd0:    start_r[z] <= cfg_data;
                            2'd1:    stop_r[z]  <= cfg_data;
                            2'd2:    en_r[z]    <= cfg_data[0];
                            default: en_r[z]    <= en_r[z];
                        endcase
                    end
                end
            end
        end
    end

    // Per-zone request, RUN-exit and arbitration-candidate terms
    always_comb begin
        req_s      = '0;
        exit_run_s = '0;
        cand_s     = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            req_s[i] = en_r[i] & ((in_window(start_r[i], stop_r[i], time_bcd) & ~inhibit[i])
                                  | ovr_r[i]);
            exit_run_s[i] = (state_r[i] == ST_RUN) &
                            (~req_s[i] | pend_off_r[i] |
                             ((MAX_RUN_S != 0) && (run_tmr_r[i] == RTW'(MAX_RUN_S - 1))));
            cand_s[i] = (state_r[i] == ST_REQ) & req_s[i] & ~pend_off_r[i];
        end
    end

    // Round-robin arbiter: nearest candidate at or after rr_r, gated by remaining capacity
    always_comb begin
        int  best_d_s;
        int  best_i_s;
        int  dist_s;
        logic grant_ok_s;
        keep_cnt_s = 5'd0;
        best_d_s   = NUM_ZONES;
        best_i_s   = 0;
        dist_s     = 0;
        gnt_s      = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            if ((state_r[i] == ST_RUN) && !exit_run_s[i]) begin
                keep_cnt_s = keep_cnt_s + 5'd1;
            end else begin
                keep_cnt_s = keep_cnt_s;
            end
        end
        for (int i = 0; i < NUM_ZONES; i++) begin
            dist_s = (i + NUM_ZONES - int'(rr_r)) % NUM_ZONES;
            if (cand_s[i] && (dist_s < best_d_s)) begin
                best_d_s = dist_s;
                best_i_s = i;
            end else begin
                best_d_s = best_d_s;
            end
        end
        grant_ok_s = tick_1hz && (best_d_s < NUM_ZONES) && (int'(keep_cnt_s) < MAX_ACTIVE);
        for (int i = 0; i < NUM_ZONES; i++) begin
            gnt_s[i] = grant_ok_s && (i == best_i_s);
        end
        if (grant_ok_s) begin
            rr_nx_s = ZW'((best_i_s + 1) % NUM_ZONES);
        end else begin
            rr_nx_s = rr_r;
        end
    end

    // Zone FSM next state and timers; everything holds on non-tick cycles
    always_comb begin
        run_mask_nx_s  = '0;
        state_vec_nx_s = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            state_nx_s[i]    = state_r[i];
            run_tmr_nx_s[i]  = run_tmr_r[i];
            hold_tmr_nx_s[i] = hold_tmr_r[i];
            if (tick_1hz) begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (req_s[i]) begin
                            state_nx_s[i] = ST_REQ;
                        end else begin
                            state_nx_s[i] = ST_IDLE;
                        end
                    end
                    ST_REQ: begin
                        if (!req_s[i] || pend_off_r[i]) begin
                            state_nx_s[i] = ST_IDLE;
                        end else if (gnt_s[i]) begin
                            state_nx_s[i]   = ST_RUN;
                            run_tmr_nx_s[i] = '0;
                        end else begin
                            state_nx_s[i] = ST_REQ;
                        end
                    end
                    ST_RUN: begin
                        if (exit_run_s[i]) begin
                            state_nx_s[i]    = ST_HOLD;
                            run_tmr_nx_s[i]  = '0;
                            hold_tmr_nx_s[i] = '0;
                        end else if (MAX_RUN_S != 0) begin
                            run_tmr_nx_s[i] = run_tmr_r[i] + RTW'(1'b1);
                        end else begin
                            run_tmr_nx_s[i] = run_tmr_r[i];
                        end
                    end
                    ST_HOLD: begin
                        if ((HOLDOFF_S == 0) || (hold_tmr_r[i] == HTW'(HOLDOFF_S - 1))) begin
                            state_nx_s[i]    = ST_IDLE;
                            hold_tmr_nx_s[i] = '0;
                        end else begin
                            hold_tmr_nx_s[i] = hold_tmr_r[i] + HTW'(1'b1);
                        end
                    end
                    default: state_nx_s[i] = ST_IDLE;
                endcase
            end else begin
                state_nx_s[i] = state_r[i];
            end
            run_mask_nx_s[i]           = (state_nx_s[i] == ST_RUN);
            state_vec_nx_s[2*i +: 2]   = state_nx_s[i];
        end
    end

    // Override latch and pending man_off; man_off beats man_on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_r      <= '0;
            pend_off_r <= '0;
        end else begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                if (man_off[i]) begin
                    ovr_r[i] <= 1'b0;
                end else if (man_on[i]) begin
                    ovr_r[i] <= 1'b1;
                end else if (tick_1hz && exit_run_s[i]) begin
                    ovr_r[i] <= 1'b0;
                end
                if (man_off[i]) begin
                    pend_off_r[i] <= 1'b1;
                end else if (tick_1hz) begin
                    pend_off_r[i] <= 1'b0;
                end
            end
        end
    end

    // FSM state, timers and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                state_r[i]    <= ST_IDLE;
                run_tmr_r[i]  <= '0;
                hold_tmr_r[i] <= '0;
            end
            rr_r <= '0;
        end else begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                state_r[i]    <= state_nx_s[i];
                run_tmr_r[i]  <= run_tmr_nx_s[i];
                hold_tmr_r[i] <= hold_tmr_nx_s[i];
            end
            rr_r <= rr_nx_s;
        end
    end

    // Registered outputs track the state being entered, so they are valid right after the tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zone_on    <= '0;
            zone_state <= '0;
            active_cnt <= 5'd0;
        end else begin
            zone_on    <= run_mask_nx_s;
            zone_state <= state_vec_nx_s;
            active_cnt <= popcnt(run_mask_nx_s);
        end
    end

endmodule

// File: doc/garden_zone_scheduler.md
Name: garden_zone_scheduler

Overview:
Parametrised multi-zone actuator scheduler for the smart garden. It generalises the fixed 21:30–21:31 single-window gate, fountain and irrigation control into N independently programmable zones. Each zone has a runtime-written start/stop window (BCD HHMM, midnight wrap allowed), a moisture inhibit, manual override, run-time limit and hold-off. A round-robin arbiter caps concurrently running zones at pump capacity. It sits after the digital clock counter and drives the motor, valve and gate enable lines.

Parameters:
NUM_ZONES, 4, number of zones N (1..16)
MAX_ACTIVE, 2, max zones in RUN simultaneously (1..NUM_ZONES)
MAX_RUN_S, 600, max ticks a zone stays in RUN; 0 = unlimited
HOLDOFF_S, 30, ticks spent in HOLD before returning to IDLE
ZW, 2, zone index width, ceil(log2(NUM_ZONES)), minimum 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
time_bcd  in  16  current time {hr2,hr1,min2,min1}, BCD
tick_1hz  in  1  one-cycle strobe; all FSM/timer updates occur only on strobe cycles
cfg_we  in  1  config write strobe
cfg_zone  in  ZW  target zone
cfg_sel  in  2  0=start, 1=stop, 2=enable (cfg_data[0]), 3=reserved
cfg_data  in  16  BCD HHMM, or enable bit
man_on  in  N  manual-on pulse per zone
man_off  in  N  manual-off pulse per zone
inhibit  in  N  soil-wet inhibit per zone (level)
zone_on  out  N  zone actuator enable
zone_state  out  2N  per-zone state, zone i at [2i+1:2i]
active_cnt  out  5  number of zones in RUN
cfg_err  out  1  one-cycle pulse on rejected write

Behaviour:
- Reset (async): all zones IDLE, start=stop=0000, enable=0, override latches clear, timers 0, rr_ptr=0, zone_on=0, zone_state=0, active_cnt=0, cfg_err=0.
- Config applies on any cycle. Reject when cfg_zone>=N, cfg_sel=3, any BCD digit >9, HH>23 or MM>59 (start/stop only). On reject: registers unchanged, cfg_err=1 next cycle. A write to an active zone takes effect at the next tick.
- Window (16-bit unsigned compare of BCD): start<stop gives in_win = start<=t<stop; start>stop (wrap) gives in_win = t>=start OR t<stop; start==stop gives never.
- Override latch ovr[i]: set on man_on[i]; cleared on man_off[i] or when zone i leaves RUN. If man_on and man_off occur in the same cycle, man_off wins. Latch captures on any cycle; man_off is also held pending until the next tick.
- req[i] = enable[i] & ((in_win & ~inhibit[i]) | ovr[i]). Override ignores window and inhibit, not enable.
- FSM per zone, evaluated on tick only. Encoding IDLE=0, REQ=1, RUN=2, HOLD=3.
  IDLE→REQ: req.
  REQ→IDLE: ~req or pending man_off.
  REQ→RUN: granted.
  RUN→HOLD: ~req, pending man_off, or run_tmr==MAX_RUN_S-1 (MAX_RUN_S≠0). Clear run_tmr.
  HOLD→IDLE: hold_tmr==HOLDOFF_S-1, or immediately if HOLDOFF_S=0. HOLD ignores requests.
- Arbiter: at most one grant per tick. Grant only if active_cnt (after this tick's RUN exits) < MAX_ACTIVE. Search REQ zones from rr_ptr upward with wrap; rr_ptr = granted+1 mod N.
- Outputs are registered. zone_on[i] = (state==RUN), valid the cycle after the deciding tick. active_cnt equals popcount of zone_on.
- Non-tick cycles: no state or timer change.
- Midnight: 2359→0000 is handled only by the window rule; no special case.

Test Plan:
- Zone0 start=2130, stop=2131, en=1; time 2129→2130 on tick → tick1 REQ, tick2 RUN, zone_on=0001; time 2131 → HOLD, IDLE after 30 ticks.
- Zone1 start=2300, stop=0100 (wrap); times 2259/2300/0030/0100 → in_win 0/1/1/0, zone1 RUN 2300–0059.
- MAX_ACTIVE=2, zones 0–3 all in window → grants on 3 successive ticks: 0, then 1, then none; active_cnt=2; zone0 man_off → zone2 granted after zone0 exits.
- Zone2 en=1, outside window, inhibit=1, man_on → RUN within 2 ticks; man_on+man_off same cycle → stays IDLE.
- MAX_RUN_S=5, zone in window → RUN exactly 5 ticks, then HOLD despite req.
- Writes cfg_data=2460, cfg_zone=3 with N=3, cfg_sel=3 → each gives cfg_err pulse; registers unchanged. Assert reset mid-RUN → zone_on=0 immediately.
